// File: rtl/cpu_multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I core.
//   state_t      : FSM states
//   halt_cause_t : reported reason the core stopped
//   OP_*         : RV32I major opcodes
//   SZ_*         : access size encoded in funct3[1:0] of loads/stores
package cpu_multicycle_pkg;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_SYSTEM   = 2'd1,
    HC_MISALIGN = 2'd2,
    HC_ILLEGAL  = 2'd3
  } halt_cause_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;

  function automatic logic is_rv32i_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Instruction and data bus of the core. Both buses use req/ready: req is held
// with stable address/controls until the cycle ready is seen.
//   master : the CPU side
//   slave  : the memory side
interface cpu_multicycle_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/cpu_multicycle_lsu_align.sv
// Byte-lane steering for loads and stores (combinational).
//   funct3     : load/store size and signedness
//   addr_lo    : byte offset within the word
//   rs2        : store source register
//   rdata      : raw load word from memory
//   be         : lane strobes (used for both loads and stores)
//   wdata      : store data replicated across lanes
//   load_data  : selected lane, sign- or zero-extended
//   misaligned : access crosses its natural alignment
module cpu_multicycle_lsu_align
  import cpu_multicycle_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    be         = 4'hF;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2[7:0]}};
        load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{rs2[15:0]}};
        load_data  = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end
endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I core with req/ready instruction and data buses.
//   clk, reset (async, active-low)
//   bus        : instruction/data bus master
//   halted     : core stopped in HALT
//   halt_cause : 0 none, 1 ECALL/EBREAK, 2 misaligned, 3 illegal opcode
//   instret    : retired-instruction count, wraps
//
// state   | meaning
// FETCH   | imem_req high at pc, wait for imem_ready, latch ir
// EXEC    | decode/execute; retire non-memory ops or launch data access
// MEM     | dmem_req high, wait for dmem_ready, retire load/store
// HALT    | terminal, no requests until reset
module cpu_multicycle
  import cpu_multicycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_multicycle_if.master     bus,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [INSTRET_W-1:0] instret
);
  state_t      state;
  logic [31:0] pc, ir;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic [31:0] alu_b, alu_out, sra_res, pc_plus4, new_pc, wb_val, mem_addr;
  logic        wb_en, take_branch;

  assign alu_b    = (opcode == OP_REG) ? rs2_val : imm_i;
  // Kept as its own signed expression so the shift stays arithmetic.
  assign sra_res  = $signed(rs1_val) >>> alu_b[4:0];
  assign pc_plus4 = pc + 32'd4;
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  always_comb begin
    alu_out = 32'd0;
    case (funct3)
      3'b000:  alu_out = (opcode == OP_REG && ir[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << alu_b[4:0];
      3'b010:  alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'b0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = ir[30] ? sra_res : rs1_val >> alu_b[4:0];
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      3'b000:  take_branch = rs1_val == rs2_val;
      3'b001:  take_branch = rs1_val != rs2_val;
      3'b100:  take_branch = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  take_branch = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  take_branch = rs1_val <  rs2_val;
      3'b111:  take_branch = rs1_val >= rs2_val;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    new_pc = pc_plus4;
    wb_val = alu_out;
    wb_en  = 1'b0;
    case (opcode)
      OP_LUI:    begin wb_val = imm_u;      wb_en = 1'b1; end
      OP_AUIPC:  begin wb_val = pc + imm_u; wb_en = 1'b1; end
      OP_JAL:    begin wb_val = pc_plus4;   wb_en = 1'b1; new_pc = pc + imm_j; end
      OP_JALR:   begin wb_val = pc_plus4;   wb_en = 1'b1; new_pc = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (take_branch) new_pc = pc + imm_b;
      OP_IMM, OP_REG: wb_en = 1'b1;
      default:   wb_en = 1'b0;
    endcase
  end

  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata, lsu_load;
  logic        lsu_misaligned;

  cpu_multicycle_lsu_align u_lsu (
    .funct3     (funct3),
    .addr_lo    (mem_addr[1:0]),
    .rs2        (rs2_val),
    .rdata      (bus.dmem_rdata),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .load_data  (lsu_load),
    .misaligned (lsu_misaligned)
  );

  // ir and rs1 are unchanged during MEM, so lsu_load already sees the
  // right lane selection when the load data arrives.
  logic        rf_we;
  logic [31:0] rf_wd;
  assign rf_we = reset && (rd != 5'd0) &&
                 ((state == S_EXEC && wb_en) ||
                  (state == S_MEM && bus.dmem_ready && !bus.dmem_we));
  assign rf_wd = (state == S_MEM) ? lsu_load : wb_val;

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= rf_wd;
  end

  assign bus.imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      ir             <= 32'd0;
      instret        <= '0;
      halted         <= 1'b0;
      halt_cause     <= HC_NONE;
      bus.imem_req   <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= 32'd0;
      bus.dmem_be    <= 4'd0;
      bus.dmem_wdata <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          bus.imem_req <= 1'b1;
          if (bus.imem_req && bus.imem_ready) begin
            ir           <= bus.imem_rdata;
            bus.imem_req <= 1'b0;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opcode == OP_LOAD || opcode == OP_STORE) begin
            if (lsu_misaligned) begin
              state      <= S_HALT;
              halted     <= 1'b1;
              halt_cause <= HC_MISALIGN;
            end else begin
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= (opcode == OP_STORE);
              bus.dmem_addr  <= {mem_addr[31:2], 2'b00};
              bus.dmem_be    <= lsu_be;
              bus.dmem_wdata <= (opcode == OP_STORE) ? lsu_wdata : 32'd0;
              state          <= S_MEM;
            end
          end else if (opcode == OP_SYSTEM) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= HC_SYSTEM;
          end else if (!is_rv32i_op(opcode)) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= HC_ILLEGAL;
          end else begin
            pc           <= new_pc;
            instret      <= instret + INSTRET_W'(1);
            bus.imem_req <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus.dmem_be  <= 4'd0;
            pc           <= pc_plus4;
            instret      <= instret + INSTRET_W'(1);
            bus.imem_req <= 1'b1;
            state        <= S_FETCH;
          end
        end
        default: begin
          bus.imem_req <= 1'b0;
          bus.dmem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
`timescale 1ns/1ps
module tb_cpu_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset1;
  cpu_multicycle_if b0();
  cpu_multicycle_if b1();
  logic        halted0, halted1;
  logic [1:0]  hc0, hc1;
  logic [31:0] instret0;
  logic [3:0]  instret1;

  cpu_multicycle #(.RESET_PC(32'h0), .INSTRET_W(32)) dut0 (
    .clk(clk), .reset(reset0), .bus(b0), .halted(halted0), .halt_cause(hc0), .instret(instret0));
  cpu_multicycle #(.RESET_PC(32'h100), .INSTRET_W(4)) dut1 (
    .clk(clk), .reset(reset1), .bus(b1), .halted(halted1), .halt_cause(hc1), .instret(instret1));

  int tests = 0;
  int failed = 0;
  int imem_wait = 0;
  int iw0 = 0, iw1 = 0;
  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:15];
  logic [31:0] st_wd[$], st_ad[$], fetch_ad[$];
  logic [3:0]  st_be[$], ld_be[$];

  // Memory models: ready is decided at the falling edge so the DUT samples
  // a stable value at the next rising edge.
  always @(negedge clk) begin
    if (b0.imem_req) begin
      if (iw0 >= imem_wait) begin
        b0.imem_ready = 1'b1;
        b0.imem_rdata = imem[b0.imem_addr[8:2]];
        fetch_ad.push_back(b0.imem_addr);
        iw0 = 0;
      end else begin
        b0.imem_ready = 1'b0;
        iw0++;
      end
    end else begin
      b0.imem_ready = 1'b0;
      iw0 = 0;
    end
    if (b0.dmem_req) begin
      b0.dmem_ready = 1'b1;
      if (b0.dmem_we) begin
        for (int k = 0; k < 4; k++)
          if (b0.dmem_be[k]) dmem[b0.dmem_addr[5:2]][8*k +: 8] = b0.dmem_wdata[8*k +: 8];
        st_wd.push_back(b0.dmem_wdata);
        st_ad.push_back(b0.dmem_addr);
        st_be.push_back(b0.dmem_be);
      end else begin
        b0.dmem_rdata = dmem[b0.dmem_addr[5:2]];
        ld_be.push_back(b0.dmem_be);
      end
    end else begin
      b0.dmem_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b1.imem_req) begin
      if (iw1 >= imem_wait) begin
        b1.imem_ready = 1'b1;
        b1.imem_rdata = imem[b1.imem_addr[8:2]];
        iw1 = 0;
      end else begin
        b1.imem_ready = 1'b0;
        iw1++;
      end
    end else begin
      b1.imem_ready = 1'b0;
      iw1 = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v, a, f, d;
    v = imm; a = rs1; f = f3; d = rd;
    return {v[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction
  function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] e_u(input logic [31:0] imm20, input int rd, input logic [6:0] op);
    logic [31:0] d;
    d = rd;
    return {imm20[19:0], d[4:0], op};
  endfunction
  function automatic logic [31:0] e_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0073;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr[8:2]] = w;
  endtask

  // Loads a full 32-bit constant into rd with LUI + ADDI at addr, addr+4.
  task automatic li(input logic [31:0] addr, input int rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = (v + 32'h800) >> 12;
    put(addr, e_u(hi, rd, 7'h37));
    put(addr + 4, e_i(int'({{20{v[11]}}, v[11:0]}), rd, 0, rd, 7'h13));
  endtask

  task automatic start0();
    reset0 = 1'b0;
    @(negedge clk);
    st_wd.delete(); st_ad.delete(); st_be.delete(); ld_be.delete(); fetch_ad.delete();
    @(negedge clk);
    reset0 = 1'b1;
  endtask

  task automatic wait_halt0(input string nm);
    int n = 0;
    while (!halted0 && n < 400) begin @(posedge clk); #1; n++; end
    check({nm, " halted"}, {31'b0, halted0}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t vecs[12];

  initial begin
    int cnt;
    vecs[0]  = '{"add",  32'd5,          32'd7,          e_r(0, 2, 1, 0, 3),    32'h0000_000C};
    vecs[1]  = '{"sub",  32'd5,          32'd7,          e_r(32, 2, 1, 0, 3),   32'hFFFF_FFFE};
    vecs[2]  = '{"sll",  32'd1,          32'd31,         e_r(0, 2, 1, 1, 3),    32'h8000_0000};
    vecs[3]  = '{"slt",  32'hFFFF_FFFF,  32'd1,          e_r(0, 2, 1, 2, 3),    32'h0000_0001};
    vecs[4]  = '{"sltu", 32'hFFFF_FFFF,  32'd1,          e_r(0, 2, 1, 3, 3),    32'h0000_0000};
    vecs[5]  = '{"xor",  32'hF0F0_F0F0,  32'h0FF0_0FF0,  e_r(0, 2, 1, 4, 3),    32'hFF00_FF00};
    vecs[6]  = '{"srl",  32'h8000_0000,  32'd4,          e_r(0, 2, 1, 5, 3),    32'h0800_0000};
    vecs[7]  = '{"sra",  32'h8000_0000,  32'd4,          e_r(32, 2, 1, 5, 3),   32'hF800_0000};
    vecs[8]  = '{"or",   32'hFF00_FF00,  32'h0FF0_0FF0,  e_r(0, 2, 1, 6, 3),    32'hFFF0_FFF0};
    vecs[9]  = '{"and",  32'hFF00_FF00,  32'h0FF0_0FF0,  e_r(0, 2, 1, 7, 3),    32'h0F00_0F00};
    vecs[10] = '{"addi", 32'd5,          32'd0,          e_i(-3, 1, 0, 3, 7'h13),   32'h0000_0002};
    vecs[11] = '{"srai", 32'h8000_0000,  32'd0,          e_i(1032, 1, 5, 3, 7'h13), 32'hFF80_0000};

    reset0 = 1'b0;
    reset1 = 1'b0;
    imem_wait = 3;
    clear_prog();
    for (int i = 0; i < 4; i++) put(32'h100 + 4*i, e_i(1, 1, 0, 1, 7'h13));

    // Reset state of the RESET_PC=0x100 core, then reset mid-fetch.
    @(negedge clk);
    check("rst halted", {31'b0, halted1}, 32'd0);
    check("rst instret", {28'b0, instret1}, 32'd0);
    check("rst cause", {30'b0, hc1}, 32'd0);
    check("rst imem_req", {31'b0, b1.imem_req}, 32'd0);
    check("rst imem_addr", b1.imem_addr, 32'h100);
    reset1 = 1'b1;
    @(posedge clk); #1;
    check("first req", {31'b0, b1.imem_req}, 32'd1);
    check("first addr", b1.imem_addr, 32'h100);
    @(negedge clk); #2;
    reset1 = 1'b0;
    #1;
    check("async req drop", {31'b0, b1.imem_req}, 32'd0);

    // Table-driven ALU vectors: x3 = op(x1, x2), stored to observe it.
    imem_wait = 0;
    foreach (vecs[i]) begin
      clear_prog();
      li(32'h0, 1, vecs[i].a);
      li(32'h8, 2, vecs[i].b);
      put(32'h10, vecs[i].instr);
      put(32'h14, e_s(0, 3, 0, 2));
      start0();
      wait_halt0(vecs[i].name);
      check({vecs[i].name, " nstore"}, st_wd.size(), 32'd1);
      if (st_wd.size() > 0) check({vecs[i].name, " result"}, st_wd[0], vecs[i].exp);
      check({vecs[i].name, " instret"}, instret0, 32'd6);
    end

    // ADDI chain, zero-wait then 3 fetch wait states: exact retire timing.
    for (int w = 0; w < 4; w += 3) begin
      imem_wait = w;
      clear_prog();
      put(32'h0, e_i(5, 0, 0, 1, 7'h13));
      put(32'h4, e_i(-3, 1, 0, 2, 7'h13));
      put(32'h8, e_s(0, 2, 0, 2));
      start0();
      @(posedge clk); #1;
      check("chain req0", {31'b0, b0.imem_req}, 32'd1);
      check("chain addr0", b0.imem_addr, 32'h0);
      repeat ((w == 0) ? 3 : 9) @(posedge clk);
      #1;
      check("chain instret mid", instret0, 32'd1);
      @(posedge clk); #1;
      check("chain instret", instret0, 32'd2);
      wait_halt0("chain");
      if (st_wd.size() > 0) check("chain x2", st_wd[0], 32'd2);
      else check("chain nstore", st_wd.size(), 32'd1);
    end
    imem_wait = 0;

    // Word store then byte loads of the top lane.
    clear_prog();
    put(32'h0, e_u(32'h80000, 1, 7'h37));
    put(32'h4, e_s(0, 1, 0, 2));
    put(32'h8, e_i(3, 0, 0, 3, 7'h03));
    put(32'hC, e_i(3, 0, 4, 4, 7'h03));
    put(32'h10, e_s(4, 3, 0, 2));
    put(32'h14, e_s(8, 4, 0, 2));
    start0();
    wait_halt0("bytes");
    check("bytes nstore", st_wd.size(), 32'd3);
    check("bytes nload", ld_be.size(), 32'd2);
    if (st_wd.size() == 3 && ld_be.size() == 2) begin
      check("sw be", {28'b0, st_be[0]}, 32'hF);
      check("sw wdata", st_wd[0], 32'h8000_0000);
      check("lb be", {28'b0, ld_be[0]}, 32'h8);
      check("lb x3", st_wd[1], 32'hFFFF_FF80);
      check("lb st addr", st_ad[1], 32'h4);
      check("lbu x4", st_wd[2], 32'h0000_0080);
      check("lbu st addr", st_ad[2], 32'h8);
    end
    check("bytes instret", instret0, 32'd6);

    // Halfword store to lane 2, then misaligned LH halts without a request.
    clear_prog();
    li(32'h0, 5, 32'h1234_ABCD);
    put(32'h8, e_s(2, 5, 0, 1));
    put(32'hC, e_i(1, 0, 1, 6, 7'h03));
    start0();
    wait_halt0("half");
    check("half ntrans", st_wd.size() + ld_be.size(), 32'd1);
    if (st_wd.size() > 0) begin
      check("sh be", {28'b0, st_be[0]}, 32'hC);
      check("sh wdata", st_wd[0], 32'hABCD_ABCD);
      check("sh addr", st_ad[0], 32'h0);
    end
    check("misalign cause", {30'b0, hc0}, 32'd2);
    check("misalign instret", instret0, 32'd3);

    // ECALL at reset PC: halts, no retire, no further fetches.
    clear_prog();
    start0();
    wait_halt0("ecall");
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b0.imem_req || b0.dmem_req) cnt++;
    end
    check("ecall cause", {30'b0, hc0}, 32'd1);
    check("ecall instret", instret0, 32'd0);
    check("ecall req after halt", cnt, 32'd0);
    check("ecall nfetch", fetch_ad.size(), 32'd1);

    // All-zero word is not an RV32I opcode.
    clear_prog();
    put(32'h0, 32'h0000_0000);
    start0();
    wait_halt0("illegal");
    check("illegal cause", {30'b0, hc0}, 32'd3);
    check("illegal instret", instret0, 32'd0);

    // JAL x1,+8 at pc 0 skips the word at 4.
    clear_prog();
    put(32'h0, e_j(8, 1));
    put(32'h4, e_i(99, 0, 0, 1, 7'h13));
    put(32'h8, e_s(0, 1, 0, 2));
    start0();
    wait_halt0("jal");
    if (fetch_ad.size() > 1) check("jal target fetch", fetch_ad[1], 32'h8);
    else check("jal nfetch", fetch_ad.size(), 32'd3);
    if (st_wd.size() > 0) check("jal link", st_wd[0], 32'h4);
    else check("jal nstore", st_wd.size(), 32'd1);
    check("jal instret", instret0, 32'd2);

    // 4-bit retire counter wraps after 16: 17 ADDIs leave 1.
    reset0 = 1'b0;
    clear_prog();
    for (int i = 0; i < 17; i++) put(32'h100 + 4*i, e_i(1, 1, 0, 1, 7'h13));
    @(negedge clk);
    reset1 = 1'b1;
    cnt = 0;
    while (!halted1 && cnt < 400) begin @(posedge clk); #1; cnt++; end
    check("wrap halted", {31'b0, halted1}, 32'd1);
    check("wrap cause", {30'b0, hc1}, 32'd1);
    check("wrap instret", {28'b0, instret1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
